// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : bram_stream_reader
// Description : Scans a contiguous address window of a BRAM on a start pulse.
//               Reads are issued back to back, accounting for the BRAM's
//               fixed read latency. The returned words are streamed out over
//               a valid/ready interface through a small credit-controlled
//               FIFO, so consumer stalls never drop read data.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_start         - one-cycle scan request (sampled when idle)
//               i_base_addr     - first word address of the window
//               i_length        - word count, 0..2^ADDR_W
//               o_busy / o_done - scan in progress / completion pulse
//               o_bram_en/addr  - BRAM read port request
//               i_bram_dout     - BRAM read data, RD_LAT cycles after request
//               o_m_data/valid  - output stream, i_m_ready is backpressure
// Revision    : 1.0 - initial release
// ============================================================================
module bram_stream_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_bram_en,
  output logic [ADDR_W-1:0] o_bram_addr,
  input  logic [DATA_W-1:0] i_bram_dout,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_valid,
  input  logic              i_m_ready
);

  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CRD_W = $clog2(FIFO_D + RD_LAT + 1);

  localparam logic [CRD_W-1:0]  c_fifo_depth = CRD_W'(FIFO_D);
  localparam logic [CNT_W-1:0]  c_count_full = CNT_W'(FIFO_D);
  localparam logic [CNT_W-1:0]  c_count_one  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  c_last_ptr   = PTR_W'(FIFO_D - 1);
  localparam logic [PTR_W-1:0]  c_ptr_one    = PTR_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_len_one    = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_zdone;       // completion pulse of a zero-length scan
  logic [ADDR_W-1:0]   r_addr;        // next address to issue
  logic [ADDR_W:0]     r_issue_left;
  logic [ADDR_W:0]     r_recv_left;
  logic [RD_LAT-1:0]   r_vld;         // one bit per read still inside the BRAM
  logic [DATA_W-1:0]   r_mem [FIFO_D];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_last_pop;
  logic [RD_LAT:0]     w_vld_shift;
  logic [CRD_W-1:0]    w_outstanding;

  // Credits: every word either sitting in the FIFO or still in the BRAM
  // pipeline has a reserved FIFO slot, so a new read may only go out while
  // that total is below the FIFO depth.
  always_comb begin
    w_outstanding = CRD_W'(r_count);
    for (int i = 0; i < RD_LAT; i++) begin
      w_outstanding = w_outstanding + CRD_W'(r_vld[i]);
    end
  end

  assign w_issue     = (r_state == S_ISSUE) && (w_outstanding < c_fifo_depth);
  assign w_push      = r_vld[RD_LAT-1];
  assign o_m_valid   = (r_count != '0);
  assign w_pop       = o_m_valid & i_m_ready;
  assign w_last_pop  = (r_state == S_DRAIN) && w_pop && (r_recv_left == c_len_one);
  assign w_vld_shift = {r_vld, w_issue};

  assign o_bram_en   = w_issue;
  assign o_bram_addr = r_addr;
  assign o_m_data    = r_mem[r_rd_ptr];
  assign o_busy      = r_busy;
  // The final transfer and done share a cycle, so done is decoded from the pop.
  assign o_done      = r_zdone | w_last_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_zdone      <= 1'b0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_recv_left  <= '0;
      r_vld        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      for (int i = 0; i < FIFO_D; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_shift[RD_LAT-1:0];

      if (w_push) begin
        r_mem[r_wr_ptr] <= i_bram_dout;
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_count_one;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_count_one;
      end

      case (r_state)
        S_IDLE: begin
          if (r_zdone) begin
            r_zdone <= 1'b0;
            r_busy  <= 1'b0;
          end else if (i_start) begin
            r_busy <= 1'b1;
            if (i_length == '0) begin
              r_zdone <= 1'b1;
            end else begin
              r_addr       <= i_base_addr;
              r_issue_left <= i_length;
              r_recv_left  <= i_length;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_addr       <= r_addr + c_addr_one;
            r_issue_left <= r_issue_left - c_len_one;
            if (r_issue_left == c_len_one) begin
              r_state <= S_DRAIN;
            end
          end
          if (w_pop) begin
            r_recv_left <= r_recv_left - c_len_one;
          end
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_recv_left <= r_recv_left - c_len_one;
          end
          if (w_last_pop) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The credit scheme must make a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (r_count == c_count_full)));
    end
  end

endmodule
`default_nettype wire
